// File: rtl/ro_thermal_sensor_if.sv
// Processor-facing register pair of the ring-oscillator temperature sensor.
interface ro_thermal_sensor_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0] reg_0;  // control, written by the processor
    logic [BUS_WIDTH-1:0] reg_1;  // status/result, read by the processor

    modport master (output reg_0, input reg_1);
    modport slave  (input reg_0, output reg_1);
endinterface

// File: rtl/ro_thermal_sensor.sv
// Ring-oscillator temperature sensor: enables a local ring, divides it, and
// counts synchronised divided edges in the Clk domain over a 2^(8+WSEL) window.
module ro_thermal_sensor #(
    parameter int BUS_WIDTH   = 32,
    parameter int NUM_LOOP    = 32,
    parameter int DIV_LOG2    = 4,
    parameter int SETTLE      = 16,
    parameter int USE_EXT_OSC = 0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    ro_thermal_sensor_if.slave regs,
    input  logic               osc_ext
);
    localparam int                 SET_W       = $clog2(SETTLE + 2);
    localparam logic [SET_W-1:0]   SETTLE_LOAD = SET_W'(SETTLE);
    localparam logic [22:0]        WIN_ONES    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t state, state_next;

    logic                run, cont;
    logic [3:0]          wsel_in;
    logic                run_prev, start;
    logic                en, div_rst_n, osc_src;
    logic [DIV_LOG2-1:0] div;
    logic                s1, s2, s3, osc_edge;
    logic [SET_W-1:0]    settle_cnt;
    logic [3:0]          wsel;
    logic [22:0]         win_cnt, acc, count;
    logic                done, aborted, busy;
    logic [3:0]          seq;
    logic                unused_ctrl;

    assign run         = regs.reg_0[0];
    assign cont        = regs.reg_0[1];
    assign wsel_in     = regs.reg_0[7:4];
    assign unused_ctrl = ^{regs.reg_0[BUS_WIDTH-1:8], regs.reg_0[3:2]};
    assign start       = run & ~run_prev;
    assign busy        = (state != IDLE);

    if (USE_EXT_OSC != 0) begin : g_ext
        assign osc_src = osc_ext;
    end else begin : g_ring
        logic [NUM_LOOP:0] chain;
        logic              unused_osc;
        assign unused_osc = osc_ext;
        // The gate ANDs en with the inverted tail so the loop holds an odd
        // number of inversions with an even inverter count; en=0 parks it.
        assign chain[0] = en & ~chain[NUM_LOOP];
        for (genvar i = 0; i < NUM_LOOP; i++) begin : g_inv
            assign chain[i+1] = ~chain[i];
        end
        assign osc_src = chain[NUM_LOOP];
    end

    assign div_rst_n = Reset_n & en;

    // Ring-domain toggle divider, held cleared whenever the ring is disabled.
    always_ff @(posedge osc_src or negedge div_rst_n) begin
        if (!div_rst_n) div <= '0;
        else            div <= div + DIV_LOG2'(1);
    end

    // Three-flop synchroniser of the divided ring clock into Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div[DIV_LOG2-1];
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign osc_edge = s2 & ~s3;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode; run low in ARM/COUNT aborts to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM: begin
                if (!run)                 state_next = IDLE;
                else if (settle_cnt == '0) state_next = COUNT;
            end
            COUNT: begin
                if (!run)               state_next = IDLE;
                else if (win_cnt == '0) state_next = LATCH;
            end
            LATCH:   state_next = (cont && run) ? ARM : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Measurement datapath: settle/window counters, accumulator, result latch.
    // ARM lasts SETTLE+1 cycles: the first lets the divider leave its
    // asynchronous reset, then SETTLE full cycles of ring settling.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_prev   <= 1'b0;
            en         <= 1'b0;
            wsel       <= '0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            acc        <= '0;
            count      <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            seq        <= '0;
        end else begin
            run_prev <= run;
            en       <= (state_next == ARM) || (state_next == COUNT);
            case (state)
                IDLE: begin
                    if (start) begin
                        aborted    <= 1'b0;
                        acc        <= '0;
                        wsel       <= wsel_in;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ARM: begin
                    if (!run) begin
                        aborted <= 1'b1;
                    end else if (settle_cnt == '0) begin
                        win_cnt <= WIN_ONES >> (4'd15 - wsel);
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                COUNT: begin
                    if (!run) begin
                        aborted <= 1'b1;
                    end else begin
                        if (osc_edge)        acc     <= acc + 23'd1;
                        if (win_cnt != '0)   win_cnt <= win_cnt - 23'd1;
                    end
                end
                LATCH: begin
                    count <= acc;
                    done  <= 1'b1;
                    seq   <= seq + 4'd1;
                    if (cont && run) begin
                        acc        <= '0;
                        wsel       <= wsel_in;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status/result word presented to the processor.
    always_comb begin
        regs.reg_1        = '0;
        regs.reg_1[31]    = done;
        regs.reg_1[30]    = busy;
        regs.reg_1[29]    = aborted;
        regs.reg_1[27:24] = seq;
        regs.reg_1[22:0]  = count;
    end
endmodule

// File: tb/tb_ro_thermal_sensor.sv
// Self-checking bench for ro_thermal_sensor driven from an external 160 MHz
// oscillator; expected results are queued at stimulus time and popped on output.
`timescale 1ns/1ps
module tb_ro_thermal_sensor;
    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;
    logic osc_ext = 1'b0;
    bit   osc_on  = 1'b1;

    int passed = 0;
    int total  = 0;
    int model_seq = 0;
    logic [22:0] last_count = '0;

    typedef struct {
        int seq;
        int lo;
        int hi;
    } exp_t;
    exp_t sb[$];

    ro_thermal_sensor_if #(.BUS_WIDTH(32)) bus ();

    ro_thermal_sensor #(
        .BUS_WIDTH  (32),
        .NUM_LOOP   (32),
        .DIV_LOG2   (4),
        .SETTLE     (16),
        .USE_EXT_OSC(1)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .regs   (bus),
        .osc_ext(osc_ext)
    );

    initial forever #5 Clk = ~Clk;

    initial begin
        #1;
        forever #3.125 if (osc_on) osc_ext = ~osc_ext;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_expect(input int wsel);
        exp_t e;
        int   w;
        w = 1 << (8 + wsel);
        model_seq = (model_seq + 1) % 16;
        e.seq = model_seq;
        if (osc_on) begin
            e.lo = w / 10;
            e.hi = w / 10 + 1;
        end else begin
            e.lo = 0;
            e.hi = 0;
        end
        sb.push_back(e);
    endtask

    // Raises run; returns just after the clock edge that samples the start edge.
    task automatic start_meas(input int wsel, input bit cont_b);
        @(posedge Clk); #1;
        bus.reg_0      = '0;
        bus.reg_0[0]   = 1'b1;
        bus.reg_0[1]   = cont_b;
        bus.reg_0[7:4] = 4'(wsel);
        @(posedge Clk); #1;
    endtask

    task automatic wait_seq(input int limit, output int n);
        logic [3:0] s0;
        s0 = bus.reg_1[27:24];
        n  = 0;
        while (n < limit && bus.reg_1[27:24] == s0) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    task automatic idle_run();
        bus.reg_0 = '0;
        repeat (4) begin @(posedge Clk); #1; end
    endtask

    task automatic test_reset();
        bit stayed_zero;
        stayed_zero = 1'b1;
        bus.reg_0 = '0;
        #1 Reset_n = 1'b0;
        #1;
        total++; if (bus.reg_1 !== 32'h0) $display("FAIL reset_reg1: got %h expected 0", bus.reg_1); else passed++;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b1;
        for (int unsigned i = 0; i < 1000; i++) begin
            @(posedge Clk); #1;
            if (bus.reg_1 !== 32'h0 || dut.en !== 1'b0) stayed_zero = 1'b0;
        end
        total++; if (stayed_zero !== 1'b1) $display("FAIL idle_quiet: got disturbance=%0d expected 0", !stayed_zero); else passed++;
        total++; if (dut.en !== 1'b0) $display("FAIL idle_en: got %b expected 0", dut.en); else passed++;
        total++; if (bus.reg_1 !== 32'h0) $display("FAIL idle_reg1: got %h expected 0", bus.reg_1); else passed++;
    endtask

    task automatic test_single();
        int   n;
        exp_t e;
        push_expect(0);
        start_meas(0, 1'b0);
        total++; if (bus.reg_1[30] !== 1'b1) $display("FAIL single_busy: got %b expected 1", bus.reg_1[30]); else passed++;
        wait_seq(2000, n);
        total++; if (n !== 274) $display("FAIL single_latency: got %0d expected 274", n); else passed++;
        total++; if (bus.reg_1[31] !== 1'b1) $display("FAIL single_done: got %b expected 1", bus.reg_1[31]); else passed++;
        e = sb.pop_front();
        total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL single_seq: got %0d expected %0d", bus.reg_1[27:24], e.seq); else passed++;
        total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL single_count: got %0d expected %0d..%0d", bus.reg_1[22:0], e.lo, e.hi); else passed++;
        total++; if (bus.reg_1[30] !== 1'b0) $display("FAIL single_idle: got busy %b expected 0", bus.reg_1[30]); else passed++;
        last_count = bus.reg_1[22:0];
        idle_run();
    endtask

    task automatic test_continuous();
        int         n;
        bit         busy_ok;
        exp_t       e;
        logic [3:0] s0;
        busy_ok = 1'b1;
        start_meas(2, 1'b1);
        for (int unsigned r = 0; r < 17; r++) begin
            push_expect(2);
            if (r == 16) bus.reg_0[1] = 1'b0;
            s0 = bus.reg_1[27:24];
            n  = 0;
            while (n < 1100 && bus.reg_1[27:24] == s0) begin
                @(posedge Clk); #1;
                n++;
                if (bus.reg_1[27:24] == s0 && bus.reg_1[30] !== 1'b1) busy_ok = 1'b0;
            end
            total++; if (n !== 1042) $display("FAIL cont_period[%0d]: got %0d expected 1042", r, n); else passed++;
            e = sb.pop_front();
            total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL cont_seq[%0d]: got %0d expected %0d", r, bus.reg_1[27:24], e.seq); else passed++;
            total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL cont_count[%0d]: got %0d expected %0d..%0d", r, bus.reg_1[22:0], e.lo, e.hi); else passed++;
        end
        total++; if (busy_ok !== 1'b1) $display("FAIL cont_busy_held: got drop=%0d expected 0", !busy_ok); else passed++;
        total++; if (bus.reg_1[30] !== 1'b0) $display("FAIL cont_stop_busy: got %b expected 0", bus.reg_1[30]); else passed++;
        last_count = bus.reg_1[22:0];
        idle_run();
    endtask

    task automatic test_abort();
        start_meas(2, 1'b0);
        repeat (117) begin @(posedge Clk); #1; end
        bus.reg_0[0] = 1'b0;
        @(posedge Clk); #1;
        total++; if (bus.reg_1[30] !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.reg_1[30]); else passed++;
        total++; if (bus.reg_1[29] !== 1'b1) $display("FAIL abort_flag: got %b expected 1", bus.reg_1[29]); else passed++;
        total++; if (dut.en !== 1'b0) $display("FAIL abort_en: got %b expected 0", dut.en); else passed++;
        total++; if (bus.reg_1[27:24] !== 4'(model_seq)) $display("FAIL abort_seq: got %0d expected %0d", bus.reg_1[27:24], model_seq); else passed++;
        total++; if (bus.reg_1[22:0] !== last_count) $display("FAIL abort_count: got %0d expected %0d", bus.reg_1[22:0], last_count); else passed++;
        total++; if (bus.reg_1[31] !== 1'b1) $display("FAIL abort_done: got %b expected 1", bus.reg_1[31]); else passed++;
        repeat (1100) begin @(posedge Clk); #1; end
        total++; if (bus.reg_1[27:24] !== 4'(model_seq)) $display("FAIL abort_no_result: got %0d expected %0d", bus.reg_1[27:24], model_seq); else passed++;
        idle_run();
    endtask

    task automatic test_rerun();
        int   n;
        exp_t e;
        push_expect(0);
        start_meas(0, 1'b0);
        total++; if (bus.reg_1[29] !== 1'b0) $display("FAIL rerun_aborted: got %b expected 0", bus.reg_1[29]); else passed++;
        wait_seq(2000, n);
        total++; if (n !== 274) $display("FAIL rerun_latency: got %0d expected 274", n); else passed++;
        e = sb.pop_front();
        total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL rerun_seq: got %0d expected %0d", bus.reg_1[27:24], e.seq); else passed++;
        total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL rerun_count: got %0d expected %0d..%0d", bus.reg_1[22:0], e.lo, e.hi); else passed++;
        last_count = bus.reg_1[22:0];
        idle_run();
    endtask

    task automatic test_const_osc();
        int   n;
        exp_t e;
        osc_on = 1'b0;
        repeat (4) begin @(posedge Clk); #1; end
        push_expect(0);
        start_meas(0, 1'b0);
        wait_seq(2000, n);
        e = sb.pop_front();
        total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL const_seq: got %0d expected %0d", bus.reg_1[27:24], e.seq); else passed++;
        total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL const_count: got %0d expected %0d..%0d", bus.reg_1[22:0], e.lo, e.hi); else passed++;
        total++; if (bus.reg_1[31] !== 1'b1) $display("FAIL const_done: got %b expected 1", bus.reg_1[31]); else passed++;
        last_count = bus.reg_1[22:0];
        osc_on = 1'b1;
        idle_run();
    endtask

    // A fresh start command (with a new WSEL) while busy is ignored, and
    // dropping run during LATCH still latches the result without an abort.
    task automatic test_back_to_back();
        int         n;
        exp_t       e;
        logic [3:0] s0;
        push_expect(0);
        start_meas(0, 1'b0);
        s0 = bus.reg_1[27:24];
        n  = 0;
        while (n < 2000 && bus.reg_1[27:24] == s0) begin
            if (n == 100) begin
                bus.reg_0      = '0;
                bus.reg_0[0]   = 1'b1;
                bus.reg_0[7:4] = 4'd2;
            end
            if (n == 273) bus.reg_0[0] = 1'b0;
            @(posedge Clk); #1;
            n++;
        end
        total++; if (n !== 274) $display("FAIL b2b_latency: got %0d expected 274", n); else passed++;
        e = sb.pop_front();
        total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL b2b_seq: got %0d expected %0d", bus.reg_1[27:24], e.seq); else passed++;
        total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL b2b_count: got %0d expected %0d..%0d", bus.reg_1[22:0], e.lo, e.hi); else passed++;
        total++; if (bus.reg_1[29] !== 1'b0) $display("FAIL latch_drop_aborted: got %b expected 0", bus.reg_1[29]); else passed++;
        total++; if (bus.reg_1[30] !== 1'b0) $display("FAIL latch_drop_busy: got %b expected 0", bus.reg_1[30]); else passed++;
        last_count = bus.reg_1[22:0];
        idle_run();
    endtask

    task automatic test_reset_mid();
        start_meas(2, 1'b0);
        repeat (300) begin @(posedge Clk); #1; end
        #2 Reset_n = 1'b0;
        #1;
        total++; if (bus.reg_1 !== 32'h0) $display("FAIL midreset_reg1: got %h expected 0", bus.reg_1); else passed++;
        total++; if (dut.en !== 1'b0) $display("FAIL midreset_en: got %b expected 0", dut.en); else passed++;
        bus.reg_0  = '0;
        model_seq  = 0;
        last_count = '0;
        @(posedge Clk); #3;
        Reset_n = 1'b1;
        repeat (4) begin @(posedge Clk); #1; end
    endtask

    task automatic test_restart();
        int   n;
        exp_t e;
        push_expect(0);
        start_meas(0, 1'b0);
        wait_seq(2000, n);
        total++; if (n !== 274) $display("FAIL restart_latency: got %0d expected 274", n); else passed++;
        e = sb.pop_front();
        total++; if (bus.reg_1[27:24] !== 4'(e.seq)) $display("FAIL restart_seq: got %0d expected %0d", bus.reg_1[27:24], e.seq); else passed++;
        total++; if (int'(bus.reg_1[22:0]) < e.lo || int'(bus.reg_1[22:0]) > e.hi) $display("FAIL restart_count: got %0d expected %0d..%0d", bus.reg_1[22:0], e.lo, e.hi); else passed++;
        idle_run();
    endtask

    initial begin
        bus.reg_0 = '0;
        test_reset();
        test_single();
        test_continuous();
        test_abort();
        test_rerun();
        test_const_osc();
        test_back_to_back();
        test_reset_mid();
        test_restart();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ro_thermal_sensor.md
Name: ro_thermal_sensor

Overview:
- Ring-oscillator temperature sensor for the partial-reconfiguration region. It is the measuring counterpart to the ring-oscillator heater.
- It enables a local ring oscillator, divides its output, and counts divided edges in the Clk domain over a programmable window. Ring frequency, and therefore the count, falls as die temperature rises.
- The processor controls it through the same slave-register pair: reg_0 is control (written by the processor), reg_1 is status/result (read by the processor).

Parameters:
- BUS_WIDTH, 32, width of reg_0 and reg_1.
- NUM_LOOP, 32, number of inverters in the sensing ring. Must be even; one AND gate closes the loop.
- DIV_LOG2, 4, ring-domain toggle divider; divided frequency = f_ring / 2^DIV_LOG2.
- SETTLE, 16, Clk cycles between ring enable and window start.
- USE_EXT_OSC, 0, when 1 the ring is replaced by port osc_ext (simulation/characterisation only).

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous, active-low reset.
- reg_0  input  BUS_WIDTH  control: [0] run, [1] continuous, [7:4] window select WSEL, others ignored.
- reg_1  output  BUS_WIDTH  status: [31] done, [30] busy, [29] aborted, [27:24] sample sequence, [22:0] edge count, others 0.
- osc_ext  input  1  external oscillator, used only when USE_EXT_OSC=1; ignored otherwise.

Behaviour:
- Clock and reset: one clock (Clk); reset (Reset_n) is asynchronous and active-low.
- Reset:
  - reg_1 = 0; state IDLE.
  - Ring enable = 0, so the ring is stopped.
  - Divider, synchroniser, counters and run-edge detector all cleared.
- Ring:
  - AND(en, loop_tail) feeds a NUM_LOOP-inverter chain.
  - en is high only in ARM and COUNT, so no self-heating while idle.
  - Ring (or osc_ext) clocks a DIV_LOG2-bit toggle counter; its MSB is osc_div.
  - Divider is reset asynchronously by !Reset_n or !en.
- Crossing: osc_div passes through a 3-flop synchroniser (s1, s2, s3) in Clk. edge = s2 & !s3.
- Window: W = 2^(8+WSEL) Clk cycles (256 .. 8,388,608). WSEL is sampled on the start edge and held for the whole measurement.
- Start edge: reg_0[0] sampled 0 in cycle t-1 and 1 in cycle t.
- FSM:
  - IDLE: on start edge go to ARM. Clear aborted and count accumulator; done and sample fields are retained.
  - ARM: busy=1, en=1 for SETTLE cycles, then go to COUNT. Edges are not counted.
  - COUNT: busy=1. The accumulator increments on each edge; the window counter decrements from W-1. When it reaches 0 (after exactly W cycles), go to LATCH.
  - LATCH (1 cycle), atomic update at the clock edge ending LATCH:
    - reg_1[22:0] = accumulator;
    - done = 1;
    - sequence = sequence+1, mod 16 (15 wraps to 0).
  - After LATCH: if reg_0[1]=1 and reg_0[0]=1, go to ARM (new WSEL sampled, no start edge needed). Otherwise go to IDLE.
- Latency: reg_1 shows the new result 1+SETTLE+W+1 cycles after the start edge; busy is 1 throughout ARM/COUNT/LATCH.
- Count width: the synchronised edge rate is ≤ Clk/2, so the maximum count is W/2 = 2^22, which fits in 23 bits. No saturation logic is needed.
- Abort: reg_0[0]=0 observed in ARM or COUNT causes:
  - next state IDLE, en=0, busy=0, aborted=1;
  - count, done and sequence unchanged (the last good result is retained).
- Other boundaries:
  - A start edge while busy has no effect.
  - reg_0[0] deasserted in the LATCH cycle: the result still latches, then IDLE with aborted=0.
  - Asynchronous reset mid-measurement: everything returns to reset values immediately.
- Accuracy: ±1 count from synchroniser phase; the bench must accept ±1.

Test Plan:
- Reset then idle 1000 cycles: reg_1==0, en==0, osc_ext toggles ignored.
- USE_EXT_OSC=1, Clk 100 MHz, osc_ext 160 MHz, DIV_LOG2=4, WSEL=0, run 0->1:
  - busy=1 next cycle;
  - done=1 exactly 274 cycles after the start edge;
  - count 25 or 26; sequence=1.
- Same setup with WSEL=2: count 102 or 103 after 1042 cycles. Then continuous=1 with run held: sequence increments every 1042 cycles, 15 wraps to 0, busy never drops.
- Abort: run dropped 100 cycles into COUNT:
  - next cycle IDLE, busy=0, aborted=1;
  - previous count and sequence unchanged.
- Rerun after abort clears aborted.
- osc_ext held constant: count = 0, done=1.
- Start edge while busy ignored.
- Reset_n pulsed low mid-COUNT: reg_1=0 asynchronously.
- Restart yields a correct count.
